cache_bus_arbiter: RTL
======================

Name: cache_bus_arbiter

Overview:
Shares the single cache-line memory bus controller between two cache requesters: port 0 is the I-cache, port 1 is the D-cache. Each requester issues whole-line loads or stores. The arbiter grants one transaction at a time using round-robin priority and forwards it to the controller's command interface. Load data is routed back to the granted requester only.

Parameters:
DATA_WIDTH, 64, bus beat width in bits
ADDR_WIDTH, 64, address width
LINE_BEATS, 8, beats per line; LINE_W = DATA_WIDTH*LINE_BEATS (512 by default)

Ports:
clk  in  1  clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
req_valid  in  2  per-requester request valid ([0]=I$, [1]=D$)
req_store  in  2  per-requester store(1)/load(0)
req_addr  in  2*ADDR_WIDTH  per-requester line address
req_wdata  in  2*LINE_W  per-requester store line
req_ready  out  2  request accepted this cycle (one-hot or zero)
resp_valid  out  2  load data valid for requester
resp_data  out  LINE_W  returned line (shared bus, qualified by resp_valid)
resp_ready  in  2  requester consumes response
command_valid  out  1  to controller: command valid
command_store  out  1  to controller: store flag
command_addr  out  ADDR_WIDTH  to controller: line address
data_in  out  LINE_W  to controller: store line
bus_ready  in  1  controller able to accept command
bus_valid  in  1  controller load data valid
data_out  in  LINE_W  controller load line
command_ready  out  1  arbiter consumes controller load data
grant_id  out  1  requester currently owning the bus
busy  out  1  transaction in flight (state != IDLE)

Behaviour:
- States: IDLE, ISSUE, WAIT_RESP, DELIVER. Reset (reset=0, asynchronous) forces IDLE, rr_ptr=0, grant_id=0, and clears the command/response registers. All outputs are 0 during and after reset.
- IDLE:
  - If any req_valid is set, pick a winner. If both are valid, the winner is rr_ptr. If one is valid, it wins.
  - Assert req_ready[winner]=1 combinationally in that cycle.
  - Latch store, addr and wdata into command registers; set grant_id=winner. Go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - command_valid=1; command_store, command_addr and data_in come from registers and are held stable until accepted.
  - Acceptance is command_valid && bus_ready.
  - On acceptance: a store goes to IDLE with rr_ptr=~grant_id; a load goes to WAIT_RESP.
  - Minimum one cycle in ISSUE, even if bus_ready is already 1.
- WAIT_RESP:
  - command_ready = bus_valid (combinational).
  - When bus_valid=1: capture data_out into the response register and go to DELIVER.
- DELIVER:
  - resp_valid[grant_id]=1; the other bit is 0. resp_data holds the captured line.
  - On resp_ready[grant_id]=1: go to IDLE with rr_ptr=~grant_id.
  - resp_ready on the non-granted port is ignored.
- Fairness:
  - rr_ptr changes only on transaction completion, so back-to-back contention alternates 0,1,0,1.
  - A lone requester may win repeatedly; rr_ptr still toggles after each of its completions.
- Request deassertion: a requester may drop req_valid before acceptance with no effect. After req_ready it must not expect the request to be retracted.
- Simultaneous events:
  - A new request arriving in the completion cycle is not considered until the next IDLE cycle.
  - Minimum turnaround: completion -> IDLE (1 cycle) -> ISSUE.
- A bus_valid seen outside WAIT_RESP is not consumed (command_ready=0).
- Reset mid-transaction aborts to IDLE. Any in-flight controller transfer is the controller's concern.
- busy=1 in ISSUE, WAIT_RESP and DELIVER. grant_id is held until the next grant.

Test Plan:
- Single load, I$ addr 0x1000, bus_ready=1, bus_valid after 10 cycles with line 0xA5.. -> req_ready[0] pulses 1 cycle; command_valid asserts with addr 0x1000, store=0; command_ready pulses once; resp_valid=2'b01 with the 0xA5 line until resp_ready[0].
- Both requesters valid continuously with loads, rr_ptr=0 after reset -> grants in order 0,1,0,1 over 4 transactions; resp_valid never goes to the wrong port.
- D$ store, addr 0x2040, wdata pattern, bus_ready held 0 for 5 cycles -> command_valid held high with stable addr and data for 6 cycles; the FSM returns to IDLE the cycle after acceptance; no resp_valid.
- Response backpressure: resp_ready[1]=0 for 7 cycles -> resp_valid[1] and resp_data stay stable; a pending req_valid[0] gets no req_ready until after completion.
- Async reset asserted in WAIT_RESP -> all outputs go to 0 immediately; after release the FSM is in IDLE, and the next contended grant goes to port 0.
- Stray bus_valid in IDLE -> command_ready stays 0; state is unchanged.

Source files
------------

// File: rtl/cache_bus_arbiter_if.sv
// cache_bus_arbiter_if
// Bundles the requester-side and controller-side handshake signals of the
// cache bus arbiter.
//   master : the arbiter's view (drives req_ready, resp_*, command_*, data_in,
//            grant_id, busy)
//   slave  : the environment's view (requesters plus memory bus controller)
// Requester-indexed vectors use bit/slice 0 for the I-cache, 1 for the D-cache.
interface cache_bus_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BEATS = 8
);
  localparam int LINE_W = DATA_WIDTH * LINE_BEATS;

  logic [1:0]              req_valid;
  logic [1:0]              req_store;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*LINE_W-1:0]     req_wdata;
  logic [1:0]              req_ready;
  logic [1:0]              resp_valid;
  logic [LINE_W-1:0]       resp_data;
  logic [1:0]              resp_ready;

  logic                    command_valid;
  logic                    command_store;
  logic [ADDR_WIDTH-1:0]   command_addr;
  logic [LINE_W-1:0]       data_in;
  logic                    bus_ready;
  logic                    bus_valid;
  logic [LINE_W-1:0]       data_out;
  logic                    command_ready;

  logic                    grant_id;
  logic                    busy;

  modport master (
    input  req_valid, req_store, req_addr, req_wdata, resp_ready,
           bus_ready, bus_valid, data_out,
    output req_ready, resp_valid, resp_data, command_valid, command_store,
           command_addr, data_in, command_ready, grant_id, busy
  );

  modport slave (
    output req_valid, req_store, req_addr, req_wdata, resp_ready,
           bus_ready, bus_valid, data_out,
    input  req_ready, resp_valid, resp_data, command_valid, command_store,
           command_addr, data_in, command_ready, grant_id, busy
  );
endinterface

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter
// Shares one cache-line memory bus controller between the I-cache (port 0)
// and the D-cache (port 1). One whole-line transaction at a time, round-robin
// between contending requesters; load data returns only to the granted port.
// Ports:
//   clk   : clock, posedge
//   reset : asynchronous active-low reset
//   bus   : cache_bus_arbiter_if.master (requester, controller, status signals)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no transaction; accept the winning request combinationally
// ISSUE     | command presented to the controller until bus_ready
// WAIT_RESP | load issued; waiting for controller line (bus_valid)
// DELIVER   | line presented to the granted requester until resp_ready
module cache_bus_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int LINE_BEATS = 8
) (
  input logic             clk,
  input logic             reset,
  cache_bus_arbiter_if.master bus
);
  localparam int LINE_W = DATA_WIDTH * LINE_BEATS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2,
    DELIVER   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                rr_ptr, rr_ptr_nxt;
  logic                grant_q, grant_nxt;
  logic                cmd_store_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [LINE_W-1:0]   cmd_wdata_q;
  logic [LINE_W-1:0]   resp_line_q;

  logic                winner;
  logic                load_cmd;
  logic                capture_line;
  logic [1:0]          req_ready_c;
  logic [1:0]          resp_valid_c;
  logic                command_valid_c;
  logic                command_ready_c;

  // Contention goes to rr_ptr; otherwise the single valid port wins.
  assign winner = (&bus.req_valid) ? rr_ptr : bus.req_valid[1];

  always_comb begin
    state_nxt       = state;
    rr_ptr_nxt      = rr_ptr;
    grant_nxt       = grant_q;
    load_cmd        = 1'b0;
    capture_line    = 1'b0;
    req_ready_c     = 2'b00;
    resp_valid_c    = 2'b00;
    command_valid_c = 1'b0;
    command_ready_c = 1'b0;
    case (state)
      IDLE: begin
        // reset gates the grant so req_ready stays 0 while reset is held.
        if ((|bus.req_valid) && reset) begin
          req_ready_c[winner] = 1'b1;
          load_cmd            = 1'b1;
          grant_nxt           = winner;
          state_nxt           = ISSUE;
        end
      end
      ISSUE: begin
        command_valid_c = 1'b1;
        if (bus.bus_ready) begin
          if (cmd_store_q) begin
            state_nxt  = IDLE;
            rr_ptr_nxt = ~grant_q;
          end else begin
            state_nxt  = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        command_ready_c = bus.bus_valid;
        if (bus.bus_valid) begin
          capture_line = 1'b1;
          state_nxt    = DELIVER;
        end
      end
      DELIVER: begin
        resp_valid_c[grant_q] = 1'b1;
        if (bus.resp_ready[grant_q]) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = ~grant_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      rr_ptr      <= 1'b0;
      grant_q     <= 1'b0;
      cmd_store_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      resp_line_q <= '0;
    end else begin
      state   <= state_nxt;
      rr_ptr  <= rr_ptr_nxt;
      grant_q <= grant_nxt;
      if (load_cmd) begin
        cmd_store_q <= bus.req_store[winner];
        cmd_addr_q  <= bus.req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        cmd_wdata_q <= bus.req_wdata[winner*LINE_W +: LINE_W];
      end
      if (capture_line) begin
        resp_line_q <= bus.data_out;
      end
    end
  end

  assign bus.req_ready     = req_ready_c;
  assign bus.resp_valid    = resp_valid_c;
  assign bus.resp_data     = resp_line_q;
  assign bus.command_valid = command_valid_c;
  assign bus.command_store = cmd_store_q;
  assign bus.command_addr  = cmd_addr_q;
  assign bus.data_in       = cmd_wdata_q;
  assign bus.command_ready = command_ready_c;
  assign bus.grant_id      = grant_q;
  assign bus.busy          = (state != IDLE);

endmodule
